// File: rtl/bank_pkg.sv
// Shared definitions for the tile-cache refill path and the tag-compare stage.
package bank_pkg;

    localparam int NUM_BANKS = 4;
    localparam int RR_W      = $clog2(NUM_BANKS);
    localparam int TAG_W     = 9;
    localparam logic [TAG_W-1:0] INVALID_TAG = '1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA,
        DONE
    } refill_state_t;

    typedef logic [NUM_BANKS-1:0] bank_sel_t;

endpackage

// File: rtl/bank_victim_sel.sv
// Victim choice: lowest-index invalid bank, otherwise the round-robin bank.
module bank_victim_sel
    import bank_pkg::*;
(
    input  logic [NUM_BANKS-1:0] bank_valid_i,
    input  logic [RR_W-1:0]      rr_i,
    output bank_sel_t            victim_o,
    output logic                 from_rr_o
);

    always_comb begin
        victim_o  = '0;
        from_rr_o = 1'b0;
        if (&bank_valid_i) begin
            victim_o  = bank_sel_t'(1 << rr_i);
            from_rr_o = 1'b1;
        end else begin
            // Walk downward so the lowest invalid index is the last one written.
            for (int i = NUM_BANKS - 1; i >= 0; i--) begin
                if (!bank_valid_i[i]) begin
                    victim_o = bank_sel_t'(1 << i);
                end
            end
        end
    end

endmodule

// File: rtl/bank_refill.sv
// Miss-side refill controller: picks a victim bank, fetches one burst, writes it
// into the bank and publishes the new per-bank tags.
module bank_refill
    import bank_pkg::NUM_BANKS, bank_pkg::RR_W, bank_pkg::bank_sel_t,
           bank_pkg::refill_state_t, bank_pkg::IDLE, bank_pkg::REQ,
           bank_pkg::DATA, bank_pkg::DONE;
#(
    parameter  int TAG_W  = 9,
    parameter  int DATA_W = 32,
    parameter  int BEATS  = 16,
    localparam int OFF_W  = $clog2(BEATS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss_valid,
    input  logic [TAG_W-1:0]       miss_tag,
    output logic                   miss_ready,
    output logic                   mem_req,
    output logic [TAG_W+OFF_W-1:0] mem_addr,
    input  logic                   mem_gnt,
    input  logic                   mem_rvalid,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   wr_en,
    output logic [NUM_BANKS-1:0]   wr_bank,
    output logic [OFF_W-1:0]       wr_offset,
    output logic [DATA_W-1:0]      wr_data,
    output logic [TAG_W-1:0]       bank0_tag,
    output logic [TAG_W-1:0]       bank1_tag,
    output logic [TAG_W-1:0]       bank2_tag,
    output logic [TAG_W-1:0]       bank3_tag,
    output logic [NUM_BANKS-1:0]   bank_valid,
    output logic                   fill_done,
    output logic [NUM_BANKS-1:0]   fill_bank
);

    localparam logic [TAG_W-1:0] INV_TAG  = '1;
    localparam logic [OFF_W-1:0] LAST_OFF = OFF_W'(BEATS - 1);

    refill_state_t        state_q, state_d;
    logic [TAG_W-1:0]     tags_q [NUM_BANKS];
    logic [NUM_BANKS-1:0] valid_q;
    logic [RR_W-1:0]      rr_q;
    logic [OFF_W-1:0]     cnt_q;
    logic [TAG_W-1:0]     tag_q;
    bank_sel_t            victim_q;
    logic                 from_rr_q;

    logic                 wr_en_q;
    bank_sel_t            wr_bank_q;
    logic [OFF_W-1:0]     wr_offset_q;
    logic [DATA_W-1:0]    wr_data_q;

    logic                 accept;
    logic                 last_beat;
    bank_sel_t            dup_sel;
    logic                 dup_hit;
    bank_sel_t            vsel;
    logic                 vfrom_rr;

    bank_victim_sel u_victim (
        .bank_valid_i (valid_q),
        .rr_i         (rr_q),
        .victim_o     (vsel),
        .from_rr_o    (vfrom_rr)
    );

    always_comb begin
        dup_sel = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            dup_sel[i] = valid_q[i] && (tags_q[i] == miss_tag);
        end
        dup_hit = |dup_sel;
    end

    always_comb begin
        state_d    = state_q;
        miss_ready = (state_q == IDLE);
        accept     = miss_valid && miss_ready;
        last_beat  = (state_q == DATA) && mem_rvalid && (cnt_q == LAST_OFF);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (dup_hit) begin
                        state_d = DONE;
                    end else if (miss_tag != INV_TAG) begin
                        state_d = REQ;
                    end
                end
            end
            REQ:     if (mem_gnt) state_d = DATA;
            DATA:    if (last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            for (int i = 0; i < NUM_BANKS; i++) tags_q[i] <= INV_TAG;
            valid_q     <= '0;
            rr_q        <= '0;
            cnt_q       <= '0;
            tag_q       <= '0;
            victim_q    <= '0;
            from_rr_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_bank_q   <= '0;
            wr_offset_q <= '0;
            wr_data_q   <= '0;
        end else begin
            state_q <= state_d;
            wr_en_q <= 1'b0;

            if (accept) begin
                if (dup_hit) begin
                    victim_q  <= dup_sel;
                    from_rr_q <= 1'b0;
                end else if (miss_tag != INV_TAG) begin
                    // Invalidate the victim immediately so tag compare cannot hit stale lines.
                    tag_q     <= miss_tag;
                    victim_q  <= vsel;
                    from_rr_q <= vfrom_rr;
                    valid_q   <= valid_q & ~vsel;
                    for (int i = 0; i < NUM_BANKS; i++) begin
                        if (vsel[i]) tags_q[i] <= INV_TAG;
                    end
                end
            end

            if ((state_q == REQ) && mem_gnt) begin
                cnt_q <= '0;
            end

            if ((state_q == DATA) && mem_rvalid) begin
                wr_en_q     <= 1'b1;
                wr_bank_q   <= victim_q;
                wr_offset_q <= cnt_q;
                wr_data_q   <= mem_rdata;
                cnt_q       <= cnt_q + 1'b1;
            end

            // Publish the tag together with the final write strobe.
            if (last_beat) begin
                valid_q <= valid_q | victim_q;
                for (int i = 0; i < NUM_BANKS; i++) begin
                    if (victim_q[i]) tags_q[i] <= tag_q;
                end
                if (from_rr_q) rr_q <= rr_q + 1'b1;
            end
        end
    end

    assign mem_req    = (state_q == REQ);
    assign mem_addr   = {tag_q, {OFF_W{1'b0}}};
    assign fill_done  = (state_q == DONE);
    assign fill_bank  = fill_done ? victim_q : '0;
    assign wr_en      = wr_en_q;
    assign wr_bank    = wr_bank_q;
    assign wr_offset  = wr_offset_q;
    assign wr_data    = wr_data_q;
    assign bank0_tag  = tags_q[0];
    assign bank1_tag  = tags_q[1];
    assign bank2_tag  = tags_q[2];
    assign bank3_tag  = tags_q[3];
    assign bank_valid = valid_q;

endmodule

// File: tb/tb_bank_refill.sv
// Directed bench for bank_refill with a write scoreboard.
module tb_bank_refill;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_valid;
    logic [8:0]  miss_tag;
    logic        miss_ready;
    logic        mem_req;
    logic [12:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        wr_en;
    logic [3:0]  wr_bank;
    logic [3:0]  wr_offset;
    logic [31:0] wr_data;
    logic [8:0]  bank0_tag, bank1_tag, bank2_tag, bank3_tag;
    logic [3:0]  bank_valid;
    logic        fill_done;
    logic [3:0]  fill_bank;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0]  bank;
        logic [3:0]  off;
        logic [31:0] data;
    } wr_t;
    wr_t sb[$];

    always #5 clk = ~clk;

    bank_refill dut (
        .clk        (clk),
        .rst        (rst),
        .miss_valid (miss_valid),
        .miss_tag   (miss_tag),
        .miss_ready (miss_ready),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .wr_en      (wr_en),
        .wr_bank    (wr_bank),
        .wr_offset  (wr_offset),
        .wr_data    (wr_data),
        .bank0_tag  (bank0_tag),
        .bank1_tag  (bank1_tag),
        .bank2_tag  (bank2_tag),
        .bank3_tag  (bank3_tag),
        .bank_valid (bank_valid),
        .fill_done  (fill_done),
        .fill_bank  (fill_bank)
    );

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    function automatic logic [8:0] tag_of(input logic [3:0] b);
        case (b)
            4'b0001: return bank0_tag;
            4'b0010: return bank1_tag;
            4'b0100: return bank2_tag;
            default: return bank3_tag;
        endcase
    endfunction

    // Advance one cycle and retire any write the DUT produced against the scoreboard.
    task automatic step();
        wr_t e;
        @(posedge clk);
        #1;
        if (wr_en) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", 64'(wr_en), 64'(0));
            end else begin
                e = sb.pop_front();
                chk("wr_bank", 64'(wr_bank), 64'(e.bank));
                chk("wr_offset", 64'(wr_offset), 64'(e.off));
                chk("wr_data", 64'(wr_data), 64'(e.data));
            end
        end
    endtask

    task automatic fill(input logic [8:0] tag, input logic [3:0] vb, input int gdly, input bit gaps);
        logic [31:0] d;
        miss_tag   = tag;
        miss_valid = 1'b1;
        step();
        miss_valid = 1'b0;
        chk("req_ready", 64'(miss_ready), 64'(0));
        chk("req_mem_req", 64'(mem_req), 64'(1));
        chk("req_addr", 64'(mem_addr), 64'({tag, 4'h0}));
        chk("req_victim_tag", 64'(tag_of(vb)), 64'(9'h1FF));
        chk("req_victim_valid", 64'(bank_valid & vb), 64'(0));
        for (int i = 0; i < gdly; i++) begin
            step();
            chk("wait_mem_req", 64'(mem_req), 64'(1));
            chk("wait_addr", 64'(mem_addr), 64'({tag, 4'h0}));
        end
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("gnt_mem_req", 64'(mem_req), 64'(0));
        for (int b = 0; b < 16; b++) begin
            d          = $urandom;
            mem_rvalid = 1'b1;
            mem_rdata  = d;
            sb.push_back('{vb, 4'(b), d});
            step();
            mem_rvalid = 1'b0;
            if (b < 15) begin
                chk("mid_fill_done", 64'(fill_done), 64'(0));
                if (gaps) begin
                    for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
                end
            end
        end
        chk("done_pulse", 64'(fill_done), 64'(1));
        chk("done_bank", 64'(fill_bank), 64'(vb));
        chk("done_tag", 64'(tag_of(vb)), 64'(tag));
        chk("done_valid", 64'(bank_valid & vb), 64'(vb));
        chk("done_sb_empty", 64'(sb.size()), 64'(0));
        chk("done_ready", 64'(miss_ready), 64'(0));
        step();
        chk("post_ready", 64'(miss_ready), 64'(1));
        chk("post_fill_done", 64'(fill_done), 64'(0));
    endtask

    initial begin
        rst        = 1'b1;
        miss_valid = 1'b0;
        miss_tag   = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_tag0", 64'(bank0_tag), 64'(9'h1FF));
        chk("rst_tag3", 64'(bank3_tag), 64'(9'h1FF));
        chk("rst_valid", 64'(bank_valid), 64'(0));
        chk("rst_ready", 64'(miss_ready), 64'(1));
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_fill_done", 64'(fill_done), 64'(0));
        chk("rst_fill_bank", 64'(fill_bank), 64'(0));
        chk("rst_wr_data", 64'(wr_data), 64'(0));

        // Cold fills land in banks 0..3 in order.
        fill(9'h010, 4'b0001, 0, 1'b0);
        fill(9'h020, 4'b0010, 0, 1'b0);
        fill(9'h030, 4'b0100, 1, 1'b0);
        fill(9'h040, 4'b1000, 0, 1'b0);
        chk("all_valid", 64'(bank_valid), 64'(4'hF));
        chk("tag0", 64'(bank0_tag), 64'(9'h010));
        chk("tag1", 64'(bank1_tag), 64'(9'h020));
        chk("tag2", 64'(bank2_tag), 64'(9'h030));
        chk("tag3", 64'(bank3_tag), 64'(9'h040));

        // Full cache: round-robin pointer starts at bank 0.
        fill(9'h050, 4'b0001, 0, 1'b0);
        chk("evict_tag0", 64'(bank0_tag), 64'(9'h050));
        chk("evict_valid", 64'(bank_valid), 64'(4'hF));

        // Duplicate miss: no memory traffic, immediate pulse.
        miss_tag   = 9'h020;
        miss_valid = 1'b1;
        step();
        miss_valid = 1'b0;
        chk("dup_fill_done", 64'(fill_done), 64'(1));
        chk("dup_fill_bank", 64'(fill_bank), 64'(4'b0010));
        chk("dup_mem_req", 64'(mem_req), 64'(0));
        chk("dup_wr_en", 64'(wr_en), 64'(0));
        chk("dup_ready", 64'(miss_ready), 64'(0));
        step();
        chk("dup_ready2", 64'(miss_ready), 64'(1));
        chk("dup_pulse_end", 64'(fill_done), 64'(0));
        chk("dup_mem_req2", 64'(mem_req), 64'(0));
        chk("dup_tag1", 64'(bank1_tag), 64'(9'h020));

        // A miss on the reserved invalid tag is dropped.
        miss_tag   = 9'h1FF;
        miss_valid = 1'b1;
        step();
        miss_valid = 1'b0;
        chk("inv_ready", 64'(miss_ready), 64'(1));
        chk("inv_mem_req", 64'(mem_req), 64'(0));
        chk("inv_fill_done", 64'(fill_done), 64'(0));
        step();
        chk("inv_fill_done2", 64'(fill_done), 64'(0));
        chk("inv_valid", 64'(bank_valid), 64'(4'hF));

        // Pointer advanced to bank 1: slow grant and gapped beats.
        fill(9'h060, 4'b0010, 5, 1'b1);
        chk("rr_tag1", 64'(bank1_tag), 64'(9'h060));
        chk("rr_tag0_kept", 64'(bank0_tag), 64'(9'h050));

        // Reset in the middle of a fill into bank 2.
        miss_tag   = 9'h070;
        miss_valid = 1'b1;
        step();
        miss_valid = 1'b0;
        chk("abort_victim_tag", 64'(bank2_tag), 64'(9'h1FF));
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int b = 0; b < 8; b++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            sb.push_back('{4'b0100, 4'(b), mem_rdata});
            step();
        end
        chk("abort_sb_empty", 64'(sb.size()), 64'(0));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_wr_en", 64'(wr_en), 64'(0));
        chk("abort_tag0", 64'(bank0_tag), 64'(9'h1FF));
        chk("abort_tag1", 64'(bank1_tag), 64'(9'h1FF));
        chk("abort_tag2", 64'(bank2_tag), 64'(9'h1FF));
        chk("abort_tag3", 64'(bank3_tag), 64'(9'h1FF));
        chk("abort_valid", 64'(bank_valid), 64'(0));
        chk("abort_mem_req", 64'(mem_req), 64'(0));
        chk("abort_ready", 64'(miss_ready), 64'(1));
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stray_beat_wr_en", 64'(wr_en), 64'(0));
        end
        mem_rvalid = 1'b0;
        fill(9'h080, 4'b0001, 0, 1'b0);
        chk("refill_valid", 64'(bank_valid), 64'(4'b0001));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bank_refill.md
# bank_refill

Miss-side refill controller for the rasterizer's 4-bank tile cache. It accepts a miss tag from the tag-compare stage, chooses a victim bank, and fetches one burst of `BEATS` words from memory. It writes those words into the victim bank's data RAM, then publishes the new per-bank tags. The tag-compare stage reads these tags.

## Interface
- `TAG_W`, 9, tag width.
- `DATA_W`, 32, memory/bank word width.
- `BEATS`, 16, words per bank line (power of two); `OFF_W` = log2(`BEATS`).
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `miss_valid`  in  1  miss request present.
- `miss_tag`  in  `TAG_W`  tag that missed.
- `miss_ready`  out  1  high only in IDLE; a miss is accepted when `miss_valid && miss_ready`.
- `mem_req`  out  1  burst request, held until granted.
- `mem_addr`  out  `TAG_W+OFF_W`  burst base `{tag, OFF_W'b0}`.
- `mem_gnt`  in  1  burst accepted.
- `mem_rvalid`  in  1  read beat valid.
- `mem_rdata`  in  `DATA_W`  read beat data.
- `wr_en`  out  1  bank write strobe (registered).
- `wr_bank`  out  4  one-hot target bank.
- `wr_offset`  out  `OFF_W`  word index within the line.
- `wr_data`  out  `DATA_W`  write data.
- `bank0_tag`..`bank3_tag`  out  `TAG_W`  each bank's current tag.
- `bank_valid`  out  4  per-bank valid.
- `fill_done`  out  1  one-cycle pulse when a line is resident.
- `fill_bank`  out  4  one-hot bank for `fill_done`.

## Operation
- States: IDLE, REQ, DATA, DONE.
- Reset values:
  - state IDLE.
  - All `bankN_tag` = `INVALID_TAG` (all-ones, 9'h1FF); `bank_valid` = 0.
  - Round-robin pointer `rr` = 0.
  - `mem_req`, `wr_en`, `fill_done` = 0; `wr_bank`, `fill_bank`, `wr_offset`, `wr_data` = 0.
- IDLE, on accept:
  - If `miss_tag` equals the tag of a valid bank (duplicate miss), go to DONE with `fill_bank` = that bank. No memory traffic occurs.
  - If `miss_tag == INVALID_TAG`, drop the miss and stay in IDLE. No pulse is produced.
  - Otherwise choose the victim: the lowest-index invalid bank; if all banks are valid, bank `rr`. Latch the tag and victim, then go to REQ.
- Entering REQ:
  - Clear the victim's valid bit.
  - Force the victim's tag output to `INVALID_TAG` so tag compare cannot hit stale data.
- REQ: `mem_req`=1 and `mem_addr`=`{tag,0}`, stable until `mem_gnt`. On grant go to DATA with beat counter = 0.
- DATA:
  - Each `mem_rvalid` registers `wr_en`=1, `wr_bank`=victim, `wr_offset`=counter, `wr_data`=`mem_rdata`, then increments the counter.
  - On beat `BEATS-1`, go to DONE.
- DONE (1 cycle):
  - Victim tag = latched tag; valid set; `fill_done`=1; `fill_bank`=victim.
  - If the victim came from `rr`, set `rr` = victim+1 mod 4.
  - Next state IDLE.
- `mem_rvalid` outside DATA is ignored.
- The counter wraps naturally; no beats beyond `BEATS` are consumed.

## Timing
- Miss accepted at cycle T: at T+1 `miss_ready`=0, `mem_req`=1, and the victim tag reads 1FF.
- `mem_gnt` is sampled only while `mem_req`=1. Grant at G gives DATA at G+1 and `mem_req`=0 at G+1.
- Beat at cycle k gives the write strobe at k+1.
- Last beat at L:
  - At L+1: final `wr_en` (offset `BEATS-1`), `fill_done`, the new tag and valid bit are all visible together.
  - At L+2: `miss_ready`=1.
- Duplicate miss at T: `fill_done` at T+1, `miss_ready` at T+2.
- Minimum fill with back-to-back beats and immediate grant is `BEATS`+3 cycles from accept to `miss_ready`.
- `rst` asserted in any state takes effect at the next edge:
  - All reset values are restored and the in-flight fill is abandoned.
  - Its remaining beats are ignored. The memory side is reset by the same `rst`.

## Structure
- Shared package `bank_pkg`:
  - `NUM_BANKS`=4, `TAG_W`, `INVALID_TAG`.
  - State enum `refill_state_t`.
  - One-hot bank select type (also used by the tag-compare stage).
- Sub-module `bank_victim_sel`: combinational. Takes `bank_valid` and `rr`, and returns the one-hot victim plus a from-`rr` flag.

## Test plan
- After reset, four misses with tags 0x010, 0x020, 0x030, 0x040 and 16 beats each fill banks 0, 1, 2, 3 in order. Tags read back exactly, and `bank_valid`=4'b1111.
- A fifth miss with tag 0x050 evicts bank 0 (`rr`=0). The bank 0 tag reads 1FF during the fill and 0x050 after it; `rr` becomes 1.
- A miss with tag 0x020 while that tag is resident in bank 1 gives no `mem_req`, `fill_done` one cycle later with `fill_bank`=4'b0010, and no `wr_en`.
- Hold `mem_gnt` low for 5 cycles, then send beats with gaps. `mem_addr` stays stable, and `wr_offset` runs 0..15 in order with data matching.
- Assert `rst` after beat 7 of a fill. All tags read 1FF and valid is 0; subsequent `mem_rvalid` produces no `wr_en`; the next miss fills bank 0.
